// File: rtl/cmd_burst_dispatcher.sv
// cmd_burst_dispatcher: pops decoded commands from an FWFT command FIFO,
// executes them against NUM_BANKS register banks and returns one response
// beat per access (burst reads give one beat per word) under ready/valid
// backpressure.
module cmd_burst_dispatcher #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned RD_LATENCY = 1,
  localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_rd_en,
  output logic [BANK_W-1:0] mem_bank_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [1:0]        resp_status,
  output logic              resp_last,
  output logic              busy,
  output logic [15:0]       cmd_count
);

  localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

  localparam logic [1:0] RESP_OK       = 2'd0;
  localparam logic [1:0] RESP_ERR_OP   = 2'd1;
  localparam logic [1:0] RESP_ERR_BANK = 2'd2;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_READ  = 3'd2,
    OP_BURST = 3'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RD_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [1:0]        resp_status_q, resp_status_d;
  logic              resp_last_q, resp_last_d;
  logic [15:0]       cmd_count_q, cmd_count_d;
  logic              bank_ok;

  // The bank field may encode values beyond NUM_BANKS when it is not a power of two
  assign bank_ok = (32'(bank_q) < NUM_BANKS);

  assign mem_bank_sel = bank_q;
  assign mem_addr     = addr_q;
  assign mem_wr_data  = data_q;
  assign resp_data    = resp_data_q;
  assign resp_addr    = addr_q;
  assign resp_status  = resp_status_q;
  assign resp_last    = resp_last_q;
  assign cmd_count    = cmd_count_q;
  assign busy         = rst && (state_q != S_IDLE);

  // Next-state and strobe logic; strobes are forced low while reset is asserted
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    bank_d        = bank_q;
    addr_d        = addr_q;
    data_d        = data_q;
    len_d         = len_q;
    beat_d        = beat_q;
    lat_d         = lat_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    resp_last_d   = resp_last_q;
    cmd_count_d   = cmd_count_q;
    cmd_rd_en     = 1'b0;
    mem_wr_en     = 1'b0;
    mem_rd_en     = 1'b0;
    resp_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_rd_en = 1'b1;
          op_d      = cmd_op;
          bank_d    = cmd_bank;
          addr_d    = cmd_addr;
          data_d    = cmd_data;
          len_d     = (cmd_op == OP_BURST) ? cmd_len : '0;
          beat_d    = '0;
          state_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        resp_data_d   = '0;
        resp_status_d = RESP_OK;
        resp_last_d   = 1'b1;
        lat_d         = '0;
        if (op_q[2]) begin
          resp_status_d = RESP_ERR_OP;
          state_d       = S_RESP;
        end else if ((op_q != OP_NOP) && !bank_ok) begin
          resp_status_d = RESP_ERR_BANK;
          state_d       = S_RESP;
        end else begin
          case (op_q)
            OP_WRITE: begin
              mem_wr_en   = 1'b1;
              resp_data_d = data_q;
              state_d     = S_RESP;
            end
            OP_READ: begin
              mem_rd_en = 1'b1;
              state_d   = S_RD_WAIT;
            end
            OP_BURST: begin
              mem_rd_en   = 1'b1;
              resp_last_d = (beat_q == len_q);
              state_d     = S_RD_WAIT;
            end
            default: begin
              state_d = S_RESP;
            end
          endcase
        end
      end

      S_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          resp_data_d = mem_rd_data;
          state_d     = S_RESP;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          if (!resp_last_q) begin
            addr_d  = addr_q + 1'b1;
            beat_d  = beat_q + 1'b1;
            state_d = S_EXEC;
          end else begin
            cmd_count_d = cmd_count_q + 16'd1;
            state_d     = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!rst) begin
      cmd_rd_en  = 1'b0;
      mem_wr_en  = 1'b0;
      mem_rd_en  = 1'b0;
      resp_valid = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      bank_q        <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      lat_q         <= '0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
      resp_last_q   <= 1'b0;
      cmd_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      bank_q        <= bank_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      lat_q         <= lat_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      resp_last_q   <= resp_last_d;
      cmd_count_q   <= cmd_count_d;
    end
  end

endmodule
